ex_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit with architectural HI/LO registers, sitting beside the ALU in the execution stage of the MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the EX stage and runs multi-cycle operations one bit per cycle. It tells the hazard logic when EX must stall, so that a dependent MFHI/MFLO or a new mul/div request waits for the result. The width is generic, so the same block serves 32-bit and reduced-width test builds.

---
 rtl/ex_muldiv_unit.sv | 205 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit with HI/LO registers for the
// EX stage. One multiply or divide bit per cycle, sign fix-up in a final cycle,
// and a combinational stall to hold dependent MFHI/MFLO or new requests in EX.
module ex_muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [2:0]       Op,
   input  logic [WIDTH-1:0] ReadData1,
   input  logic [WIDTH-1:0] ReadData2,
   input  logic             HiLoRead,
   input  logic             Flush,
   output logic             Busy,
   output logic             Stall,
   output logic             Done,
   output logic             DivByZero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int unsigned ACC_W = 2 * WIDTH;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      OP_NONE  = 3'b000,
      OP_MULT  = 3'b001,
      OP_MULTU = 3'b010,
      OP_DIV   = 3'b011,
      OP_DIVU  = 3'b100,
      OP_MTHI  = 3'b101,
      OP_MTLO  = 3'b110
   } op_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
   logic [ACC_W-1:0] acc;
   // Multiplicand magnitude for multiply, divisor magnitude for divide.
   logic [WIDTH-1:0] opnd;
   logic             is_div;
   logic             prod_neg;
   logic             quo_neg;
   logic             rem_neg;

   op_t              op_in;
   logic             is_signed;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] rs_mag;
   logic [WIDTH-1:0] rt_mag;
   logic [WIDTH:0]   mul_sum;
   logic [ACC_W-1:0] mul_next;
   logic [WIDTH:0]   div_shift;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;
   logic [ACC_W-1:0] div_next;
   logic [ACC_W-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [WIDTH-1:0] rem_fix;

   assign op_in = op_t'(Op);

   // Requests already waiting in EX, or HI/LO readers, must hold while an operation runs.
   assign Stall = Busy & (Start | HiLoRead);

   // Operand magnitudes, one iteration step for each operation, and final sign fix-up.
   always_comb begin
      is_signed = 1'b0;
      a_neg     = 1'b0;
      b_neg     = 1'b0;
      rs_mag    = ReadData1;
      rt_mag    = ReadData2;
      mul_sum   = '0;
      mul_next  = '0;
      div_shift = '0;
      div_ge    = 1'b0;
      div_diff  = '0;
      div_next  = '0;
      prod_fix  = acc;
      quo_fix   = acc[WIDTH-1:0];
      rem_fix   = acc[ACC_W-1:WIDTH];

      is_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
      a_neg     = is_signed & ReadData1[WIDTH-1];
      b_neg     = is_signed & ReadData2[WIDTH-1];
      // Most-negative keeps its bit pattern, which is its correct unsigned magnitude.
      rs_mag    = a_neg ? (~ReadData1 + WIDTH'(1)) : ReadData1;
      rt_mag    = b_neg ? (~ReadData2 + WIDTH'(1)) : ReadData2;

      // Shift-add: conditionally add multiplicand to the upper half, then shift right with carry.
      mul_sum   = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH + 1){1'b0}});
      mul_next  = {mul_sum, acc[WIDTH-1:1]};

      // Restoring divide: shift next dividend bit into the remainder and trial-subtract.
      div_shift = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
      div_ge    = div_shift >= {1'b0, opnd};
      div_diff  = div_shift[WIDTH-1:0] - opnd;
      div_next  = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

      prod_fix  = prod_neg ? (~acc + ACC_W'(1)) : acc;
      quo_fix   = quo_neg ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
      rem_fix   = rem_neg ? (~acc[ACC_W-1:WIDTH] + WIDTH'(1)) : acc[ACC_W-1:WIDTH];
   end

   // Control FSM, iteration datapath and HI/LO commit.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= S_IDLE;
         count     <= '0;
         acc       <= '0;
         opnd      <= '0;
         is_div    <= 1'b0;
         prod_neg  <= 1'b0;
         quo_neg   <= 1'b0;
         rem_neg   <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         HI        <= '0;
         LO        <= '0;
      end else begin
         Done      <= 1'b0;
         DivByZero <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Start && !Flush) begin
                  case (op_in)
                     OP_MULT, OP_MULTU: begin
                        opnd     <= rs_mag;
                        acc      <= {{WIDTH{1'b0}}, rt_mag};
                        is_div   <= 1'b0;
                        prod_neg <= a_neg ^ b_neg;
                        quo_neg  <= 1'b0;
                        rem_neg  <= 1'b0;
                        count    <= CNT_W'(WIDTH);
                        state    <= S_RUN;
                        Busy     <= 1'b1;
                     end
                     OP_DIV, OP_DIVU: begin
                        if (ReadData2 == '0) begin
                           // No iterations: report the fault and leave HI/LO untouched.
                           Done      <= 1'b1;
                           DivByZero <= 1'b1;
                        end else begin
                           opnd     <= rt_mag;
                           acc      <= {{WIDTH{1'b0}}, rs_mag};
                           is_div   <= 1'b1;
                           prod_neg <= 1'b0;
                           quo_neg  <= a_neg ^ b_neg;
                           rem_neg  <= a_neg;
                           count    <= CNT_W'(WIDTH);
                           state    <= S_RUN;
                           Busy     <= 1'b1;
                        end
                     end
                     OP_MTHI: HI <= ReadData1;
                     OP_MTLO: LO <= ReadData1;
                     default: ;
                  endcase
               end
            end
            S_RUN: begin
               if (Flush) begin
                  state <= S_IDLE;
                  Busy  <= 1'b0;
               end else begin
                  acc   <= is_div ? div_next : mul_next;
                  count <= count - CNT_W'(1);
                  if (count == CNT_W'(1)) begin
                     state <= S_FIX;
                  end
               end
            end
            S_FIX: begin
               state <= S_IDLE;
               Busy  <= 1'b0;
               // A squash in the commit cycle wins: nothing is written.
               if (!Flush) begin
                  Done <= 1'b1;
                  if (is_div) begin
                     HI <= rem_fix;
                     LO <= quo_fix;
                  end else begin
                     HI <= prod_fix[ACC_W-1:WIDTH];
                     LO <= prod_fix[WIDTH-1:0];
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed steps with a result scoreboard, at WIDTH 32 and 8.
module tb_ex_muldiv_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [2:0]  op32;
   logic [31:0] a32;
   logic [31:0] b32;
   logic        hilo;
   logic        flush;
   logic        busy32;
   logic        stall32;
   logic        done32;
   logic        dbz32;
   logic [31:0] hi32;
   logic [31:0] lo32;

   logic        start8;
   logic [2:0]  op8;
   logic [7:0]  a8;
   logic [7:0]  b8;
   logic        hilo8;
   logic        flush8;
   logic        busy8;
   logic        stall8;
   logic        done8;
   logic        dbz8;
   logic [7:0]  hi8;
   logic [7:0]  lo8;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   ex_muldiv_unit #(.WIDTH(32)) dut32 (
      .Clk(clk), .Reset(rst), .Start(start), .Op(op32),
      .ReadData1(a32), .ReadData2(b32), .HiLoRead(hilo), .Flush(flush),
      .Busy(busy32), .Stall(stall32), .Done(done32), .DivByZero(dbz32),
      .HI(hi32), .LO(lo32)
   );

   ex_muldiv_unit #(.WIDTH(8)) dut8 (
      .Clk(clk), .Reset(rst), .Start(start8), .Op(op8),
      .ReadData1(a8), .ReadData2(b8), .HiLoRead(hilo8), .Flush(flush8),
      .Busy(busy8), .Stall(stall8), .Done(done8), .DivByZero(dbz8),
      .HI(hi8), .LO(lo8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo, input logic dbz);
      exp_t e;
      e.hi  = hi;
      e.lo  = lo;
      e.dbz = dbz;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge just after the accepting edge E0.
   task automatic issue(input bit sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (sel) begin
         start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      end else begin
         start = 1'b1; op32 = op; a32 = a; b32 = b;
      end
      @(negedge clk);
      start = 1'b0; op32 = 3'b000;
      start8 = 1'b0; op8 = 3'b000;
   endtask

   // Counts edges after E0 until Done is seen, then pops and compares the scoreboard.
   task automatic wait_done(input bit sel, input int exp_lat, input string tag);
      int   n;
      exp_t e;
      n = 0;
      while (!(sel ? done8 : done32) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 64'(n), 64'(exp_lat));
      if (sb.size() == 0) begin
         check({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_hi"}, 64'(sel ? {24'd0, hi8} : hi32), 64'(e.hi));
         check({tag, "_lo"}, 64'(sel ? {24'd0, lo8} : lo32), 64'(e.lo));
         check({tag, "_dbz"}, 64'(sel ? dbz8 : dbz32), 64'(e.dbz));
      end
   endtask

   initial begin
      int done_seen;
      rst = 1'b1;
      start = 1'b0; op32 = '0; a32 = '0; b32 = '0; hilo = 1'b0; flush = 1'b0;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0; hilo8 = 1'b0; flush8 = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_hi", 64'(hi32), 64'd0);
      check("reset_lo", 64'(lo32), 64'd0);
      check("reset_busy", 64'(busy32), 64'd0);
      check("reset_done", 64'(done32), 64'd0);
      check("reset_dbz", 64'(dbz32), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // MULT 7 * -3; Done observed 33 edges after E0 (high in the cycle ending at E0+34)
      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      issue(0, 3'b001, 32'd7, 32'hFFFF_FFFD);
      check("mult_busy", 64'(busy32), 64'd1);
      wait_done(0, 33, "mult_neg");
      check("mult_busy_fell", 64'(busy32), 64'd0);

      // Back-to-back: new Start driven in the Done cycle
      push_exp(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      issue(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("b2b_done_pulse", 64'(done32), 64'd0);
      check("b2b_busy", 64'(busy32), 64'd1);
      wait_done(0, 33, "multu_max");
      push_exp(32'h4000_0000, 32'h0, 1'b0);
      issue(0, 3'b001, 32'h8000_0000, 32'h8000_0000);
      wait_done(0, 33, "mult_minneg");

      push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      issue(0, 3'b011, 32'hFFFF_FFF9, 32'd2);
      wait_done(0, 33, "div_neg");
      push_exp(32'd2, 32'd14, 1'b0);
      issue(0, 3'b100, 32'd100, 32'd7);
      wait_done(0, 33, "divu");
      push_exp(32'h0, 32'h8000_0000, 1'b0);
      issue(0, 3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(0, 33, "div_overflow");

      issue(0, 3'b101, 32'h11, 32'h0);
      check("mthi", 64'(hi32), 64'h11);
      check("mthi_busy", 64'(busy32), 64'd0);
      issue(0, 3'b110, 32'h22, 32'h0);
      check("mtlo", 64'(lo32), 64'h22);

      // Divide by zero: one-cycle Done/DivByZero, HI/LO kept
      push_exp(32'h11, 32'h22, 1'b1);
      issue(0, 3'b011, 32'd5, 32'd0);
      check("div0_busy", 64'(busy32), 64'd0);
      wait_done(0, 0, "div0");
      @(negedge clk);
      check("div0_done_clear", 64'(done32), 64'd0);
      check("div0_dbz_clear", 64'(dbz32), 64'd0);

      // Stall from cycle 3 while busy, then flush at cycle 10
      issue(0, 3'b001, 32'd5, 32'd6);
      repeat (2) @(negedge clk);
      hilo = 1'b1;
      for (int c = 3; c < 10; c++) begin
         #1 check("stall_hilo", 64'(stall32), 64'd1);
         @(negedge clk);
      end
      hilo = 1'b0;
      start = 1'b1; op32 = 3'b110; a32 = 32'hDEAD;
      #1 check("stall_start", 64'(stall32), 64'd1);
      flush = 1'b1;
      @(negedge clk);
      start = 1'b0; op32 = 3'b000; flush = 1'b0;
      check("flush_busy", 64'(busy32), 64'd0);
      check("flush_done", 64'(done32), 64'd0);
      check("flush_hi", 64'(hi32), 64'h11);
      check("flush_lo", 64'(lo32), 64'h22);
      #1 check("flush_stall", 64'(stall32), 64'd0);
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done32) done_seen++;
      end
      check("flush_no_done", 64'(done_seen), 64'd0);

      issue(0, 3'b110, 32'hABCD, 32'h0);
      check("mtlo_abcd", 64'(lo32), 64'hABCD);

      // Asynchronous reset mid-run at cycle 15
      issue(0, 3'b010, 32'd9, 32'd9);
      repeat (14) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst_busy", 64'(busy32), 64'd0);
      check("async_rst_hi", 64'(hi32), 64'd0);
      check("async_rst_lo", 64'(lo32), 64'd0);
      check("async_rst_done", 64'(done32), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push_exp(32'd0, 32'd12, 1'b0);
      issue(0, 3'b010, 32'd3, 32'd4);
      wait_done(0, 33, "multu_after_rst");

      // WIDTH=8: Done observed 9 edges after E0 (high in the cycle ending at E0+10)
      push_exp(32'hFE, 32'h01, 1'b0);
      issue(1, 3'b010, 32'hFF, 32'hFF);
      check("w8_busy", 64'(busy8), 64'd1);
      wait_done(1, 9, "w8_multu");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
